writeback_regfile: RTL
======================

# writeback_regfile

Writeback stage plus architectural register file for the pipelined core. Consumes the memory→writeback pipeline register outputs (PCSrcW, RegWriteW, MemtoRegW, WA3W, ALUOutW, ReadDataW) and selects the writeback result. It commits the result into a 15-entry register file (R0–R14) and serves three combinational read ports to the decode stage. R15 reads return PC+8, and writes to the PC are redirected to fetch.

## Interface
- WIDTH, 32, datapath width
- CNT_W, 16, width of commit counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low
- PCSrcW  in  1  instruction in writeback writes the PC
- RegWriteW  in  1  instruction in writeback writes a register
- MemtoRegW  in  1  result source: 1 = ReadDataW, 0 = ALUOutW
- WA3W  in  4  destination register number
- ALUOutW  in  WIDTH  ALU result from writeback pipeline register
- ReadDataW  in  WIDTH  load data from writeback pipeline register
- ra1, ra2, ra3  in  4 each  decode-stage read addresses
- pc_plus8  in  WIDTH  value returned for reads of R15
- rd1, rd2, rd3  out  WIDTH each  read data
- ResultW  out  WIDTH  selected writeback result
- pc_wr  out  1  fetch must load ResultW into PC
- commit_cnt  out  CNT_W  number of committed writebacks

## Operation
- ResultW = MemtoRegW ? ReadDataW : ALUOutW (combinational, always driven).
- Write enable: we = RegWriteW & (WA3W != 4'hF). When we=1, regs[WA3W] ← ResultW on the rising clk.
- WA3W = 15 never touches the array, regardless of RegWriteW.
- pc_wr = PCSrcW (combinational pass-through). Fetch uses ResultW as the target.
- Read port n (n = 1..3), evaluated in priority order:
  - ra_n = 15 → pc_plus8.
  - Otherwise, we=1 and ra_n = WA3W → ResultW (write-through bypass).
  - Otherwise → regs[ra_n].
- All three ports are independent and may address the same register.
- commit_cnt increments by 1 on every rising clk where (RegWriteW | PCSrcW) = 1. It wraps modulo 2^CNT_W (all-ones → 0) and has no saturation.
- WA3W, ALUOutW, ReadDataW and MemtoRegW may be X when RegWriteW = PCSrcW = 0. The array and counter must remain unaffected in that case.
- Reset (reset = 0):
  - Immediately, without waiting for clk: R0–R14 = 0 and commit_cnt = 0.
  - While reset is held low, writes and counts are suppressed.
  - A write coinciding with reset assertion is lost.
  - Read ports stay combinational during reset: they return 0, pc_plus8, or bypass data.
  - Outputs after reset: rd_n = 0 for ra_n ≠ 15; ResultW and pc_wr follow their inputs.

## Timing
- Read latency 0: rd_n is a combinational function of ra_n, the array, and the writeback inputs.
- Write latency 1: the array is updated at the rising clk ending the cycle in which we=1.
  - The same-cycle value is visible through the bypass.
  - The array value is visible from the next cycle.
- Back-to-back writes to the same register in consecutive cycles: each is committed; the last one wins. The bypass always shows the current cycle's ResultW.
- Reset release: the first rising clk with reset = 1 may write.
- No stalls and no handshake: the block accepts one writeback per cycle unconditionally.

## Test plan
- Reset: drive reset = 0 mid-cycle after writing R3 = 0x1234 → rd1 (ra1 = 3) = 0 immediately with no clk edge, and commit_cnt = 0.
- Write/read: RegWriteW = 1, MemtoRegW = 0, WA3W = 5, ALUOutW = 0xDEADBEEF; same cycle ra2 = 5 → rd2 = 0xDEADBEEF (bypass). Next cycle, with RegWriteW = 0 → rd2 = 0xDEADBEEF (array), commit_cnt = 1.
- Result mux: MemtoRegW = 1, ReadDataW = 0x00000055, ALUOutW = 0xFFFFFFFF, WA3W = 7 → ResultW = 0x55. Next cycle rd3 (ra3 = 7) = 0x55.
- R15 handling: RegWriteW = 1, PCSrcW = 1, WA3W = 15, ALUOutW = 0x100, pc_plus8 = 0x208, ra1 = 15 → pc_wr = 1, ResultW = 0x100, rd1 = 0x208. R0–R14 are unchanged and commit_cnt increments.
- Idle with X data: RegWriteW = PCSrcW = 0, WA3W / ALUOutW = X for 5 cycles → all registers unchanged and commit_cnt unchanged.
- Counter wrap: with CNT_W = 4, perform 17 consecutive writes → commit_cnt = 1. Also write R1 = 1, 2, 3 on consecutive cycles → rd1 = 3 afterwards.

Source files
------------

// File: rtl/writeback_regfile.sv
// Writeback stage and 15-entry architectural register file: selects the result, commits
// it to R0-R14, serves three bypassed read ports (R15 reads as PC+8), and counts commits.
module writeback_regfile #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcW,
  input  logic             RegWriteW,
  input  logic             MemtoRegW,
  input  logic [3:0]       WA3W,
  input  logic [WIDTH-1:0] ALUOutW,
  input  logic [WIDTH-1:0] ReadDataW,
  input  logic [3:0]       ra1,
  input  logic [3:0]       ra2,
  input  logic [3:0]       ra3,
  input  logic [WIDTH-1:0] pc_plus8,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic [WIDTH-1:0] ResultW,
  output logic             pc_wr,
  output logic [CNT_W-1:0] commit_cnt
);

  localparam int NREGS = 15;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we;
  logic             commit;

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
  assign pc_wr   = PCSrcW;
  // R15 is the PC: a write to it goes to fetch, never into the array.
  assign we      = RegWriteW & (WA3W != 4'hF);
  assign commit  = RegWriteW | PCSrcW;

  // Priority: R15 -> PC+8, then same-cycle bypass, then the array.
  function automatic logic [WIDTH-1:0] read_port(input logic [3:0] ra);
    logic [WIDTH-1:0] v;
    v = '0;
    if (ra == 4'hF) begin
      v = pc_plus8;
    end else if (we && (ra == WA3W)) begin
      v = ResultW;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (ra == 4'(i)) v = regs_q[i];
      end
    end
    return v;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
    rd3 = read_port(ra3);
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // holding its old value and a latch is never inferred.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && (WA3W == 4'(i))) regs_d[i] = ResultW;
    end
    cnt_d = cnt_q + CNT_W'(commit);
  end

  // NOTE: the array is small and must read as zero straight out of reset, so it is built
  // from resettable flops rather than a RAM macro, which could not be cleared asynchronously.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      cnt_q <= cnt_d;
    end
  end

  assign commit_cnt = cnt_q;

endmodule
